// File: rtl/serial_adder_pkg.sv
// Shared definitions for serial_adder: FSM state encoding and the counter-width helper.
package serial_adder_pkg;

    // IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Ceiling log2 with a minimum result of 1, so a single-digit adder still gets a 1-bit counter.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from a chain of full-adder cells.
module digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] sum,
    output logic             c_out
);

    logic [DIGIT:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: {c_out, sum} = a + b + c_in computed DIGIT bits per cycle, LSB digit first,
// with a start/busy/done handshake. WIDTH must be >= 2 and a multiple of DIGIT.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = clog2(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [DIGIT-1:0]  dig_sum;
    logic              dig_cout;
    logic [WIDTH-1:0]  sum_shift;
    logic              accept;
    logic              last_digit;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .c_in  (carry_q),
        .sum   (dig_sum),
        .c_out (dig_cout)
    );

    // New result digits enter the sum register from the MSB side.
    if (DIGIT == WIDTH) begin : g_shift_full
        assign sum_shift = dig_sum;
    end else begin : g_shift_part
        assign sum_shift = {dig_sum, sum_q[WIDTH-1:DIGIT]};
    end

    assign last_digit = (state_q == StRun) && (cnt_q == CntLast);

    // Next-state logic: accept in IDLE/DONE, one digit per RUN cycle, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;

        case (state_q)
            StIdle: begin
                accept = start;
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_shift;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                accept = start;
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = c_in;
            cnt_d   = '0;
            state_d = StRun;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is recovered as sum_msb ^ a_msb ^ b_msb of the final digit.
    always_comb begin
        ovf_d = ovf_q;
        if (last_digit) begin
            ovf_d = dig_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_cout;
        end
    end

    // Overflow flag register, held alongside sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_last;
    assign unused_last = last_digit;
`endif

    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign c_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (8x1, 8x4, 4x2), vector table,
// random operands against an arithmetic model, handshake, reset-abort and exhaustive sweep.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Two 8-bit instances share operands but have their own start.
    logic [7:0] a8, b8;
    logic       cin8;
    logic       start0, start1;
    logic       busy0, done0, cout0, busy1, done1, cout1;
    logic [7:0] sum0, sum1;
    logic [3:0] a4, b4, sum2;
    logic       cin4, start2, busy2, done2, cout2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf0, ovf1, ovf2;
`endif

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .start (start0), .a (a8), .b (b8), .c_in (cin8),
        .busy (busy0), .done (done0), .sum (sum0), .c_out (cout0)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf (ovf0)
`endif
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .start (start1), .a (a8), .b (b8), .c_in (cin8),
        .busy (busy1), .done (done1), .sum (sum1), .c_out (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf (ovf1)
`endif
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut2 (
        .clk (clk), .rst_n (rst_n), .start (start2), .a (a4), .b (b4), .c_in (cin4),
        .busy (busy2), .done (done2), .sum (sum2), .c_out (cout2)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf (ovf2)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] res;
        logic       ovf;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic.
    function automatic logic [8:0] model_sum8(input logic [7:0] a, input logic [7:0] b,
                                              input logic cin);
        int s;
        s = int'(a) + int'(b) + int'(cin);
        return s[8:0];
    endfunction

    function automatic logic model_ovf8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (s > 127) || (s < -128);
    endfunction

    function automatic logic model_ovf4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (s > 7) || (s < -8);
    endfunction

    function automatic logic cur_done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    function automatic logic cur_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic [8:0] cur_res(input int sel);
        return (sel == 0) ? {cout0, sum0} : {cout1, sum1};
    endfunction

`ifdef SERIAL_ADDER_OVF_EN
    function automatic logic cur_ovf(input int sel);
        return (sel == 0) ? ovf0 : ovf1;
    endfunction
`endif

    // One complete operation on an 8-bit instance; operands are scrambled after acceptance.
    task automatic op8(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [8:0] exp, input logic exp_ovf, input string tag);
        int lat;
        int busy_cnt;
        int n;
        n = (sel == 0) ? 8 : 2;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        a8 = ~a; b8 = ~b; cin8 = ~cin;
        lat = 0;
        busy_cnt = 0;
        while (!cur_done(sel) && lat < 40) begin
            if (cur_busy(sel)) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, n);
        check({tag, " busy cycles"}, busy_cnt, n);
        check({tag, " busy at done"}, cur_busy(sel), 0);
        check({tag, " result"}, cur_res(sel), exp);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, cur_ovf(sel), exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("note: unknown ovf expectation in %s", tag);
`endif
        @(negedge clk);
        check({tag, " done pulse width"}, cur_done(sel), 0);
        check({tag, " result held"}, cur_res(sel), exp);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        int lat;
        int s;
        s = int'(a) + int'(b) + int'(cin);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = cin; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        a4 = ~a; b4 = ~b; cin4 = ~cin;
        lat = 0;
        while (!done2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("sweep latency", lat, 2);
        check("sweep result", {cout2, sum2}, s[4:0]);
`ifdef SERIAL_ADDER_OVF_EN
        check("sweep ovf", ovf2, model_ovf4(a, b, cin));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hv [0:40];
        logic [7:0] ra, rb;
        logic       rc;
        bit         saw_done;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 9'h010, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0};
        tbl[3] = '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 9'h001, 1'b0};
        tbl[6] = '{8'h55, 8'hAA, 1'b0, 9'h0FF, 1'b0};
        tbl[7] = '{8'h7F, 8'h7F, 1'b1, 9'h0FF, 1'b1};
        tbl[8] = '{8'h80, 8'hFF, 1'b0, 9'h17F, 1'b1};
        tbl[9] = '{8'h00, 8'h00, 1'b0, 9'h000, 1'b0};

        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy0, 0);
        check("reset done", done0, 0);
        check("reset result", {cout0, sum0}, 0);
        check("reset result dut1", {cout1, sum1}, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf", ovf0, 0);
`endif
        rst_n = 1'b1;

        // Vector table on both 8-bit instances.
        for (int i = 0; i < 10; i++) begin
            op8(0, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].res, tbl[i].ovf, $sformatf("vec%0d d1", i));
            op8(1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].res, tbl[i].ovf, $sformatf("vec%0d d4", i));
        end

        // Random operands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            op8(i % 2, ra, rb, rc, model_sum8(ra, rb, rc), model_ovf8(ra, rb, rc),
                $sformatf("rand%0d", i));
        end

        // Handshake: start held high, a changes every cycle; accepts happen only in IDLE/DONE.
        b8 = 8'h3C;
        cin8 = 1'b1;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("b2b done cycle %0d", i), done0, (i % 9) == 0);
                if ((i % 9) == 0) begin
                    check($sformatf("b2b result cycle %0d", i), {cout0, sum0},
                          model_sum8(hv[i-9], 8'h3C, 1'b1));
                end
            end
            hv[i] = 8'($urandom);
            a8 = hv[i];
            start0 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        repeat (12) @(negedge clk);

        // Reset during RUN cycle 3 aborts the operation.
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-abort busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy0, 0);
        check("abort done", done0, 0);
        check("abort result", {cout0, sum0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0) saw_done = 1'b1;
        end
        check("no done after abort", saw_done, 0);
        op8(0, 8'h05, 8'h03, 1'b0, 9'h008, 1'b0, "post-abort");

        // Exhaustive sweep on the 4-bit, 2-digit instance.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    op4(4'(ia), 4'(ib), 1'(ic));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, clocked successor to the team's single-bit combinational full adder.
- Adds two WIDTH-bit operands plus a carry-in over WIDTH/DIGIT cycles, processing DIGIT bits per cycle, LSB digit first.
- A start/done handshake makes it usable as an area-lean arithmetic unit behind a controller or an accumulator datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 2.
- DIGIT, 1, bits added per cycle; must divide WIDTH exactly. DIGIT = WIDTH gives a single-cycle registered adder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B, latched on accepted start.
- c_in  input  1  carry-in, latched on accepted start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when sum/c_out become valid.
- sum  output  WIDTH  result; holds until next accepted start completes.
- c_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low forces state IDLE; busy, done, sum, c_out and internal digit counter/operand registers all 0.
- N = WIDTH/DIGIT. Counter width is clog2(N), minimum 1.
- States are IDLE, RUN and DONE.
- IDLE: start=1 at an edge latches a, b and c_in into shift registers, clears the counter and goes to RUN. start=0 stays IDLE.
- RUN: each edge adds the low DIGIT bits of the A/B registers plus the running carry. The DIGIT result bits shift into the sum register from the MSB side; A/B shift right by DIGIT; the carry is registered; the counter increments.
  - After the Nth RUN edge: state goes to DONE, sum holds the full result, c_out = final carry, busy=0, done=1.
- Latency: done is high exactly N cycles after the edge that accepted start; busy is high for exactly N cycles.
- DONE lasts one cycle. If start=1 there, the new operands are accepted (back-to-back, no idle cycle) and the state goes to RUN. Otherwise the state goes to IDLE.
- start during RUN is ignored; operands are not re-latched and the result is unaffected.
- sum/c_out are not valid while busy. The sum register is reused as a shift register, so intermediate values are visible; consumers qualify on done.
- Arithmetic is modulo 2^WIDTH on sum with carry on c_out: {c_out,sum} = a + b + c_in exactly.
- Reset asserted mid-RUN aborts the operation, with all outputs at reset values. After release the unit is IDLE; no done pulse for the aborted operation.
- a/b/c_in changes after acceptance have no effect.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit) = two's-complement signed overflow, i.e. carry into MSB XOR carry out of MSB. It is valid with done, held with sum, and reset to 0.
- Undefined: port and logic are absent; the interface is exactly as listed above.

Decomposition:
- Package serial_adder_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2 helper function for the counter width.
- One natural sub-module, digit_adder: a combinational DIGIT-bit ripple adder with inputs a, b and c_in, and outputs sum and c_out. It is built as a chain of full-adder cells and instantiated once per serial_adder.

Test Plan:
- Basic add (WIDTH=8, DIGIT=1): a=0x0F, b=0x01, c_in=0, start for 1 cycle -> busy for 8 cycles; done pulse 8 cycles after accept; sum=0x10, c_out=0.
- Carry out / wrap: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
- DIGIT=4 with macro: a=0x7F, b=0x01 -> done 2 cycles after accept; sum=0x80, c_out=0, ovf=1. a=0x80, b=0x80 -> sum=0x00, c_out=1, ovf=1.
- Handshake: start held high throughout with a changing every cycle -> only the first value is used; start is accepted again in the DONE cycle (back-to-back); done pulses every N+1 cycles.
- Reset mid-op: assert rst_n=0 at RUN cycle 3 of 8 -> busy, done, sum and c_out go to 0 immediately. After release, no done until a new start; a=0x05, b=0x03 -> sum=0x08.
- Exhaustive sweep (WIDTH=4, DIGIT=2): all 512 (a, b, c_in) combinations -> {c_out,sum} matches a+b+c_in; done latency is always 2.
